// File: rtl/control_unit.sv
// Multi-cycle control FSM: IDLE -> FETCH -> DECODE -> EXEC, with HALT.
// Drives datapath write select, input mux, ALU op and immediate for one EXEC cycle.
module control_unit #(
    parameter int BIT_WIDTH = 4,
    parameter int PC_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [BIT_WIDTH+2:0] imem_data,
    input  logic                 carry_in,
    output logic [PC_WIDTH-1:0]  imem_addr,
    output logic [1:0]           reg_addr,
    output logic                 s_reg,
    output logic                 s,
    output logic [BIT_WIDTH-1:0] imm,
    output logic                 halted
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] HALT   = 3'd4;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDA = 3'b001;
    localparam logic [2:0] OP_LDB = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_OUT = 3'b101;
    localparam logic [2:0] OP_JC  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    logic [2:0]           state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [BIT_WIDTH+2:0] ir_q, ir_d;
    logic                 cflag_q, cflag_d;
    logic                 arith_q, arith_d;

    logic [2:0]           op;
    logic [BIT_WIDTH-1:0] operand;

    assign op      = ir_q[BIT_WIDTH+2:BIT_WIDTH];
    assign operand = ir_q[BIT_WIDTH-1:0];

    // arith_q marks that the last EXEC was ADD/SUB, so the ALU carry
    // registered on that edge is captured during the following FETCH.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cflag_d = cflag_q;
        arith_d = arith_q;
        unique case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                state_d = DECODE;
                if (arith_q) begin
                    cflag_d = carry_in;
                    arith_d = 1'b0;
                end
            end
            DECODE: begin
                ir_d    = imem_data;
                state_d = EXEC;
            end
            EXEC: begin
                arith_d = (op == OP_ADD) || (op == OP_SUB);
                if (op == OP_HLT) begin
                    state_d = HALT;
                end else begin
                    state_d = FETCH;
                    if (op == OP_JC && cflag_q)
                        pc_d = operand[PC_WIDTH-1:0];
                    else
                        pc_d = pc_q + PC_WIDTH'(1);
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            cflag_q <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cflag_q <= cflag_d;
            arith_q <= arith_d;
        end
    end

    always_comb begin
        reg_addr = 2'b11;
        s_reg    = 1'b0;
        s        = 1'b0;
        imm      = '0;
        if (state_q == EXEC) begin
            unique case (op)
                OP_LDA: begin
                    reg_addr = 2'b00;
                    s_reg    = 1'b1;
                    imm      = operand;
                end
                OP_LDB: begin
                    reg_addr = 2'b01;
                    s_reg    = 1'b1;
                    imm      = operand;
                end
                OP_ADD: reg_addr = 2'b00;
                OP_SUB: begin
                    reg_addr = 2'b00;
                    s        = 1'b1;
                end
                OP_OUT: reg_addr = 2'b10;
                OP_NOP, OP_JC, OP_HLT: ;
                default: ;
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: ISA-level model predicts datapath writes,
// final PC and halt status; a negedge monitor checks every EXEC write.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [6:0] imem_data;
    logic       carry_in;
    logic [3:0] imem_addr;
    logic [1:0] reg_addr;
    logic       s_reg;
    logic       s;
    logic [3:0] imm;
    logic       halted;

    int vectors     = 0;
    int miscompares = 0;

    control_unit #(.BIT_WIDTH(4), .PC_WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .imem_data (imem_data),
        .carry_in  (carry_in),
        .imem_addr (imem_addr),
        .reg_addr  (reg_addr),
        .s_reg     (s_reg),
        .s         (s),
        .imm       (imm),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // synchronous instruction memory
    logic [6:0] mem [16];
    always @(posedge clk) imem_data <= mem[imem_addr];

    // minimal datapath supplying a registered carry
    logic [3:0] dp_a, dp_b, dp_o;
    logic       dp_c;
    logic       force_c0 = 1'b0;
    logic [4:0] alu;
    always_comb
        alu = s ? ({1'b0, dp_a} + {1'b0, ~dp_b} + 5'd1)
                : ({1'b0, dp_a} + {1'b0, dp_b});
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_a <= 4'd0; dp_b <= 4'd0; dp_o <= 4'd0; dp_c <= 1'b0;
        end else begin
            case (reg_addr)
                2'b00: begin
                    dp_a <= s_reg ? imm : alu[3:0];
                    if (!s_reg) dp_c <= alu[4];
                end
                2'b01: dp_b <= s_reg ? imm : alu[3:0];
                2'b10: dp_o <= dp_a;
                default: ;
            endcase
        end
    end
    assign carry_in = dp_c & ~force_c0;

    typedef struct packed {
        logic [1:0] ra;
        logic       sr;
        logic       sub;
        logic [3:0] im;
    } ev_t;

    ev_t exp_q[$];
    bit  mon_en = 1'b0;
    ev_t mon_act, mon_exp;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mon_en && reg_addr !== 2'b11) begin
            mon_act = '{reg_addr, s_reg, s, imm};
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(mon_act), 32'hFFFF);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("exec_ctrl", 32'(mon_act), 32'(mon_exp));
            end
        end
    end

    // ISA-level reference: runs k instructions from address 0
    task automatic model(input int k, output logic [3:0] epc, output bit eh);
        logic [3:0] pc, a, b, d;
        logic [2:0] op;
        int         sum;
        bit         cf;
        pc = 0; a = 0; b = 0; cf = 0; eh = 0;
        for (int i = 0; i < k; i++) begin
            op = mem[pc][6:4];
            d  = mem[pc][3:0];
            if (op == 3'd7) begin
                eh = 1;
                break;
            end
            case (op)
                3'd1: begin a = d; exp_q.push_back('{2'b00, 1'b1, 1'b0, d}); end
                3'd2: begin b = d; exp_q.push_back('{2'b01, 1'b1, 1'b0, d}); end
                3'd3: begin
                    sum = int'(a) + int'(b);
                    cf  = force_c0 ? 1'b0 : (sum > 15);
                    a   = 4'(sum);
                    exp_q.push_back('{2'b00, 1'b0, 1'b0, 4'd0});
                end
                3'd4: begin
                    cf = force_c0 ? 1'b0 : (a >= b);
                    a  = a - b;
                    exp_q.push_back('{2'b00, 1'b0, 1'b1, 4'd0});
                end
                3'd5: exp_q.push_back('{2'b10, 1'b0, 1'b0, 4'd0});
                default: ;
            endcase
            if (op == 3'd6 && cf) pc = d;
            else pc = pc + 4'd1;
        end
        epc = pc;
    endtask

    // reset, check idle outputs, then pulse run; returns #1 after first FETCH edge
    task automatic start(input int k, output logic [3:0] epc, output bit eh);
        rst = 1'b1; run = 1'b0; mon_en = 1'b0;
        @(posedge clk); #1;
        chk("reset_outputs", {imem_addr, reg_addr, s_reg, s, imm, halted},
            {4'd0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0});
        exp_q.delete();
        model(k, epc, eh);
        mon_en = 1'b1;
        rst = 1'b0;
        @(negedge clk); run = 1'b1;
        @(posedge clk); #1; run = 1'b0;
    endtask

    task automatic run_prog(input int k, input bit tog);
        logic [3:0] epc;
        bit         eh;
        start(k, epc, eh);
        for (int c = 0; c < 3 * k; c++) begin
            @(posedge clk); #1;
            if (tog) run = 1'($urandom_range(0, 1));
        end
        chk("end_pc", 32'(imem_addr), 32'(epc));
        chk("end_halted", 32'(halted), 32'(eh));
        chk("queue_drained", exp_q.size(), 0);
        mon_en = 1'b0;
        run = 1'b0;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) mem[i] = 7'h00;
    endtask

    initial begin
        logic [3:0] epc;
        bit         eh;
        logic [2:0] rop;

        // LDA timing: controls only in the 3rd cycle after IDLE
        fill_nop();
        mem[0] = 7'b001_0101;
        start(1, epc, eh);
        chk("lda_fetch", 32'(reg_addr), 32'h3);
        @(posedge clk); #1;
        chk("lda_decode", 32'(reg_addr), 32'h3);
        @(posedge clk); #1;
        chk("lda_exec", {reg_addr, s_reg, s, imm}, {2'b00, 1'b1, 1'b0, 4'b0101});
        @(posedge clk); #1;
        chk("lda_after", {reg_addr, s_reg, imm, imem_addr},
            {2'b11, 1'b0, 4'd0, 4'd1});
        chk("lda_queue", exp_q.size(), 0);
        mon_en = 1'b0;

        // reset asserted during EXEC abandons the instruction
        for (int i = 0; i < 16; i++) mem[i] = 7'b001_0011;
        start(1, epc, eh);
        mon_en = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("mid_exec_ctrl", 32'(reg_addr), 32'h0);
        rst = 1'b1; #1;
        chk("mid_exec_reset", {imem_addr, reg_addr, s_reg, s, imm, halted},
            {4'd0, 2'b11, 1'b0, 1'b0, 4'd0, 1'b0});
        run_prog(2, 1'b0);

        // JC taken
        fill_nop();
        mem[0] = 7'b001_1001; mem[1] = 7'b010_1000;
        mem[2] = 7'b011_0000; mem[3] = 7'b110_0111;
        mem[7] = 7'b101_0000;
        run_prog(5, 1'b0);
        run_prog(4, 1'b0);

        // JC not taken
        force_c0 = 1'b1;
        run_prog(4, 1'b0);
        run_prog(6, 1'b0);
        force_c0 = 1'b0;

        // HLT at address 2, run toggled while halted
        fill_nop();
        mem[2] = 7'b111_1010;
        run_prog(3, 1'b1);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            run = 1'($urandom_range(0, 1));
        end
        chk("halt_hold", {halted, imem_addr, reg_addr}, {1'b1, 4'd2, 2'b11});
        run = 1'b0;

        // PC wrap after 16 NOPs
        fill_nop();
        run_prog(16, 1'b1);
        run_prog(18, 1'b0);

        // random programs
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 16; i++) begin
                rop = 3'($urandom_range(0, 7));
                if (rop == 3'd7 && $urandom_range(0, 3) != 0) rop = 3'd0;
                mem[i] = {rop, 4'($urandom_range(0, 15))};
            end
            run_prog(30, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 4: data/immediate width; must match the ALU datapath it drives.
REQ-002 SHALL have parameter PC_WIDTH, default 4: program counter width; PC_WIDTH <= BIT_WIDTH.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port run, input, 1: start request, sampled only in IDLE.
REQ-006 SHALL have port imem_data, input, 3+BIT_WIDTH: instruction word; opcode = bits [BIT_WIDTH+2:BIT_WIDTH], operand = bits [BIT_WIDTH-1:0].
REQ-007 SHALL have port carry_in, input, 1: registered carry from the ALU datapath.
REQ-008 SHALL have port imem_addr, output, PC_WIDTH: instruction address, always equal to PC.
REQ-009 SHALL have port reg_addr, output, 2: datapath write select (00 = A, 01 = B, 10 = O, 11 = no write).
REQ-010 SHALL have port s_reg, output, 1: datapath input mux select (1 = imm, 0 = ALU result).
REQ-011 SHALL have port s, output, 1: ALU operation (0 = add, 1 = subtract).
REQ-012 SHALL have port imm, output, BIT_WIDTH: immediate data to the datapath.
REQ-013 SHALL have port halted, output, 1: high while in HALT.

Function
REQ-014 SHALL implement the FSM states IDLE, FETCH, DECODE, EXEC and HALT.
REQ-015 SHALL go from IDLE to FETCH when run=1, and otherwise stay in IDLE.
REQ-016 SHALL go from FETCH to DECODE, from DECODE to EXEC, and from EXEC to FETCH (or to HALT for HLT).
REQ-017 SHALL hold imem_addr=PC in FETCH, treat instruction memory as synchronous (1-cycle read latency), and latch imem_data into IR at the end of DECODE.
REQ-018 SHALL drive the idle values reg_addr=11, s_reg=0, s=0, imm=0 in every state except EXEC.
REQ-019 SHALL drive decoded controls for exactly one cycle in EXEC, so datapath writes occur on the edge that ends EXEC.
REQ-020 SHALL decode opcodes as follows:
- 000 NOP: idle values.
- 001 LDA: reg_addr=00, s_reg=1, imm=operand.
- 010 LDB: reg_addr=01, s_reg=1, imm=operand.
- 011 ADD: reg_addr=00, s_reg=0, s=0.
- 100 SUB: reg_addr=00, s_reg=0, s=1.
- 101 OUT: reg_addr=10.
- 110 JC: idle values; jump if flag set.
- 111 HLT: idle values; next state HALT.
REQ-021 SHALL, at the end of the FETCH that immediately follows an ADD or SUB EXEC, load the internal carry flag c_flag from carry_in; at all other times c_flag SHALL hold its value.
REQ-022 SHALL set PC to operand[PC_WIDTH-1:0] at the end of EXEC for JC when c_flag=1; otherwise PC SHALL become PC+1 at the end of every EXEC except HLT.
REQ-023 SHALL wrap PC from 2^PC_WIDTH-1 to 0 without error.
REQ-024 SHALL take 3 cycles per instruction; run is ignored outside IDLE.
REQ-025 SHALL keep HALT until rst, with PC frozen at the HLT address, halted=1 and idle outputs.

Reset
REQ-026 SHALL, on rst=1 and independent of clk, immediately force state=IDLE, PC=0, IR=0, c_flag=0, imem_addr=0, idle control outputs and halted=0.
REQ-027 SHALL, on reset asserted mid-instruction (including during EXEC), abandon that instruction with no further datapath write and no PC update.

Verification
REQ-028 SHALL have a bench verify reset: assert rst mid-run -> all outputs take reset values in the same cycle; after release and run=1 the next fetch is at imem_addr=0.
REQ-029 SHALL have a bench verify LDA: mem[0]=001_0101, run pulse -> reg_addr=00, s_reg=1, imm=0101 exactly in the 3rd cycle after leaving IDLE, then idle; PC=1.
REQ-030 SHALL have a bench verify taken JC: program LDA 9, LDB 8, ADD, JC 7 with carry_in=1 after ADD -> c_flag=1, next fetch at imem_addr=7.
REQ-031 SHALL have a bench verify not-taken JC: same program with carry_in=0 after ADD -> next fetch at imem_addr=4.
REQ-032 SHALL have a bench verify HLT: mem[2]=111_xxxx -> halted=1 from the cycle after EXEC, PC stays 2, and run toggling has no effect.
REQ-033 SHALL have a bench verify PC wrap: 16 NOPs -> fetch after address 15 is at address 0, and reg_addr stays 11 throughout.
